// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared definitions for the two-requester APB master.
//   - FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   - slave-select field position within the byte address
//   - address-map constants for the GPIO and UART slaves
//   - default ACCESS-phase timeout
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int SLV_MSB = 15;
  localparam int SLV_LSB = 12;

  localparam logic [3:0] SLV_GPIO = 4'h0;
  localparam logic [3:0] SLV_UART = 4'h1;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   PCLK, PRESETn (async, active-high) - clock / reset
//   req_i[1:0]  - request vector
//   accept_i    - grant is consumed this cycle; pointer advances
//   gnt_o[1:0]  - one-hot grant (combinational), 0 when no request
module rr_arbiter2 (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // Index of the requester granted last. Reset to 1 so req0 wins the
  // first contended arbitration.
  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn)                     last_q <= 1'b1;
    else if (accept_i && |gnt_o)     last_q <= gnt_o[1];
  end

endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB bus between two command requesters.
//   PCLK, PRESETn (async, active-high)
//   reqN_*  : command in (valid/write/addr/wdata/strb), reqN_ready out
//   rspN_*  : one-cycle response pulse with rdata/err
//   PADDR/PWRITE/PWDATA/PSTRB/PENABLE, PSEL_GPIO/PSEL_UART : APB out
//   PRDATA_*/PREADY_*/PSLVERR_* : per-slave APB returns
// Address bits [15:12] select the slave; other values error without a bus cycle.
module apb_rr_master
  import apb_master_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                req0_valid,
  input  logic                req0_write,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_strb,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic                req1_write,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_strb,
  output logic                req1_ready,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp0_err,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                rsp1_err,
  output logic [ADDR_W-1:0]   PADDR,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  output logic                PENABLE,
  output logic                PSEL_GPIO,
  output logic                PSEL_UART,
  input  logic [DATA_W-1:0]   PRDATA_GPIO,
  input  logic [DATA_W-1:0]   PRDATA_UART,
  input  logic                PREADY_GPIO,
  input  logic                PREADY_UART,
  input  logic                PSLVERR_GPIO,
  input  logic                PSLVERR_UART
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic                uart_q, uart_d;   // selected slave: 1=UART, 0=GPIO
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // ---- arbitration ----
  logic [1:0] gnt;
  logic       accept;

  assign accept = (state_q == ST_IDLE) && (req0_valid || req1_valid);

  rr_arbiter2 u_arb (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];

  // ---- incoming command mux + decode ----
  logic                in_write;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_wdata;
  logic [DATA_W/8-1:0] in_strb;
  logic [3:0]          in_slv;
  logic                in_hit;

  assign in_write = gnt[1] ? req1_write : req0_write;
  assign in_addr  = gnt[1] ? req1_addr  : req0_addr;
  assign in_wdata = gnt[1] ? req1_wdata : req0_wdata;
  assign in_strb  = gnt[1] ? req1_strb  : req0_strb;
  assign in_slv   = in_addr[SLV_MSB:SLV_LSB];
  assign in_hit   = (in_slv == SLV_GPIO) || (in_slv == SLV_UART);

  // ---- selected slave return path ----
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;

  assign sel_ready = uart_q ? PREADY_UART  : PREADY_GPIO;
  assign sel_err   = uart_q ? PSLVERR_UART : PSLVERR_GPIO;
  assign sel_rdata = uart_q ? PRDATA_UART  : PRDATA_GPIO;

  // ---- FSM ----
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    uart_d  = uart_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = gnt[1];
          write_d = in_write;
          addr_d  = in_addr;
          wdata_d = in_wdata;
          strb_d  = in_strb;
          uart_d  = (in_slv == SLV_UART);
          rdata_d = '0;
          err_d   = !in_hit;
          state_d = in_hit ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (sel_ready) begin
          // rdata stays 0 for writes and slave errors
          rdata_d = (write_q || sel_err) ? '0 : sel_rdata;
          err_d   = sel_err;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th cycle without PREADY: abort
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      uart_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      uart_q  <= uart_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- outputs ----
  logic on_bus, in_resp;

  assign on_bus  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign in_resp = (state_q == ST_RESP);

  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PSEL_GPIO = on_bus && !uart_q;
  assign PSEL_UART = on_bus &&  uart_q;

  assign rsp0_valid = in_resp && !owner_q;
  assign rsp1_valid = in_resp &&  owner_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : '0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
module tb_apb_rr_master;

  logic        PCLK, PRESETn;
  logic        req0_valid, req0_write, req0_ready;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_strb;
  logic        req1_valid, req1_write, req1_ready;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_strb;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PENABLE, PSEL_GPIO, PSEL_UART;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA_GPIO, PRDATA_UART;
  logic        PREADY_GPIO, PREADY_UART, PSLVERR_GPIO, PSLVERR_UART;

  int checks = 0;
  int errors = 0;

  apb_rr_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PENABLE(PENABLE), .PSEL_GPIO(PSEL_GPIO), .PSEL_UART(PSEL_UART),
    .PRDATA_GPIO(PRDATA_GPIO), .PRDATA_UART(PRDATA_UART),
    .PREADY_GPIO(PREADY_GPIO), .PREADY_UART(PREADY_UART),
    .PSLVERR_GPIO(PSLVERR_GPIO), .PSLVERR_UART(PSLVERR_UART)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int nacc[2];

  initial begin
    PRESETn = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0; req0_strb = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0; req1_strb = 0;
    PRDATA_GPIO = 0; PRDATA_UART = 0;
    PREADY_GPIO = 0; PREADY_UART = 0; PSLVERR_GPIO = 0; PSLVERR_UART = 0;
    nacc[0] = 0; nacc[1] = 0;

    // reset state
    repeat (2) @(negedge PCLK);
    #1;
    chk("rst_psel_gpio", PSEL_GPIO, 0);
    chk("rst_psel_uart", PSEL_UART, 0);
    chk("rst_penable",   PENABLE,   0);
    chk("rst_paddr",     PADDR,     0);
    chk("rst_rsp0",      rsp0_valid, 0);
    chk("rst_rsp1",      rsp1_valid, 0);

    // T1: req0 GPIO write, zero wait states
    @(negedge PCLK);
    PRESETn = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 32'h1; req0_wdata = 32'hFF; req0_strb = 4'h1;
    PREADY_GPIO = 1;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    @(negedge PCLK); req0_valid = 0; #1;           // t+1 SETUP
    chk("t1_setup_psel",   PSEL_GPIO, 1);
    chk("t1_setup_pen",    PENABLE,   0);
    chk("t1_setup_uart",   PSEL_UART, 0);
    chk("t1_setup_paddr",  PADDR,     32'h1);
    chk("t1_setup_pwrite", PWRITE,    1);
    chk("t1_setup_pwdata", PWDATA,    32'hFF);
    chk("t1_setup_pstrb",  PSTRB,     4'h1);
    @(negedge PCLK); #1;                           // t+2 ACCESS
    chk("t1_acc_psel", PSEL_GPIO, 1);
    chk("t1_acc_pen",  PENABLE,   1);
    @(negedge PCLK); #1;                           // t+3 RESP
    chk("t1_rsp_valid", rsp0_valid, 1);
    chk("t1_rsp_err",   rsp0_err,   0);
    chk("t1_rsp_rdata", rsp0_rdata, 0);
    chk("t1_rsp_psel",  PSEL_GPIO,  0);
    chk("t1_rsp1_idle", rsp1_valid, 0);
    @(negedge PCLK); #1;                           // IDLE
    chk("t1_rsp_pulse", rsp0_valid, 0);

    // T2: req1 UART read, 3 wait states
    req1_valid = 1; req1_write = 0; req1_addr = 32'h1000; req1_wdata = 0; req1_strb = 0;
    PREADY_UART = 0; PRDATA_UART = 32'hDEAD;
    #1;
    chk("t2_ready1", req1_ready, 1);
    @(negedge PCLK); req1_valid = 0; #1;
    chk("t2_setup_psel", PSEL_UART, 1);
    chk("t2_setup_pen",  PENABLE,   0);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      chk("t2_wait_psel",   PSEL_UART, 1);
      chk("t2_wait_pen",    PENABLE,   1);
      chk("t2_wait_paddr",  PADDR,     32'h1000);
      chk("t2_wait_pwrite", PWRITE,    0);
      chk("t2_wait_rsp",    rsp1_valid, 0);
    end
    @(negedge PCLK);                               // t+5
    PREADY_UART = 1; PRDATA_UART = 32'hA5;
    #1;
    chk("t2_ready_pen", PENABLE, 1);
    @(negedge PCLK); #1;                           // t+6
    chk("t2_rsp_valid", rsp1_valid, 1);
    chk("t2_rsp_rdata", rsp1_rdata, 32'hA5);
    chk("t2_rsp_err",   rsp1_err,   0);
    chk("t2_rsp_psel",  PSEL_UART,  0);
    chk("t2_rsp_pen",   PENABLE,    0);
    @(negedge PCLK);                               // IDLE

    // T3: both requesters continuously valid, 4 commands each
    req0_valid = 1; req0_write = 1; req0_addr = 32'h4; req0_wdata = 32'h11; req0_strb = 4'hF;
    req1_valid = 1; req1_write = 1; req1_addr = 32'h8; req1_wdata = 32'h22; req1_strb = 4'hF;
    PREADY_GPIO = 1;
    for (int k = 0; k < 8; k++) begin
      int e;
      e = k % 2;
      #1;
      chk("t3_ready0", req0_ready, (e == 0));
      chk("t3_ready1", req1_ready, (e == 1));
      nacc[e]++;
      @(negedge PCLK);
      if (nacc[0] == 4) req0_valid = 0;
      if (nacc[1] == 4) req1_valid = 0;
      @(negedge PCLK);
      @(negedge PCLK); #1;                         // RESP
      chk("t3_rsp0", rsp0_valid, (e == 0));
      chk("t3_rsp1", rsp1_valid, (e == 1));
      chk("t3_resp_nogrant", {req1_ready, req0_ready}, 2'b00);
      @(negedge PCLK);                             // IDLE
    end

    // T4: decode miss
    req0_valid = 1; req0_write = 0; req0_addr = 32'h3000;
    #1;
    chk("t4_ready0", req0_ready, 1);
    @(negedge PCLK); req0_valid = 0; #1;
    chk("t4_rsp_valid", rsp0_valid, 1);
    chk("t4_rsp_err",   rsp0_err,   1);
    chk("t4_rsp_rdata", rsp0_rdata, 0);
    chk("t4_no_psel",   {PSEL_UART, PSEL_GPIO}, 2'b00);
    @(negedge PCLK); #1;
    chk("t4_pulse", rsp0_valid, 0);

    // T5: GPIO timeout, then a normal read, then a slave-error write
    PREADY_GPIO = 0; PRDATA_GPIO = 32'hBEEF;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h10;
    #1;
    chk("t5_ready1", req1_ready, 1);
    @(negedge PCLK); req1_valid = 0;               // t+1 SETUP
    repeat (16) @(negedge PCLK);                   // t+17, last ACCESS cycle
    #1;
    chk("t5_last_pen",  PENABLE,    1);
    chk("t5_last_psel", PSEL_GPIO,  1);
    chk("t5_last_rsp",  rsp1_valid, 0);
    @(negedge PCLK); #1;                           // t+18 RESP
    chk("t5_to_valid", rsp1_valid, 1);
    chk("t5_to_err",   rsp1_err,   1);
    chk("t5_to_rdata", rsp1_rdata, 0);
    chk("t5_to_psel",  PSEL_GPIO,  0);
    chk("t5_to_pen",   PENABLE,    0);
    @(negedge PCLK);
    PREADY_GPIO = 1; PRDATA_GPIO = 32'h1234;
    req1_valid = 1; req1_addr = 32'h20;
    #1;
    chk("t5b_ready1", req1_ready, 1);
    @(negedge PCLK); req1_valid = 0;
    @(negedge PCLK);
    @(negedge PCLK); #1;
    chk("t5b_valid", rsp1_valid, 1);
    chk("t5b_rdata", rsp1_rdata, 32'h1234);
    chk("t5b_err",   rsp1_err,   0);
    @(negedge PCLK);
    PSLVERR_GPIO = 1;
    req0_valid = 1; req0_write = 1; req0_addr = 32'h24;
    #1;
    chk("t5c_ready0", req0_ready, 1);
    @(negedge PCLK); req0_valid = 0;
    @(negedge PCLK);
    @(negedge PCLK); #1;
    chk("t5c_valid", rsp0_valid, 1);
    chk("t5c_err",   rsp0_err,   1);
    chk("t5c_rdata", rsp0_rdata, 0);
    @(negedge PCLK);
    PSLVERR_GPIO = 0;

    // T6: reset during ACCESS; last grant is req0 so only reset brings req0 back to favour
    PREADY_GPIO = 0;
    req0_valid = 1; req0_write = 1; req0_addr = 32'h8;
    #1;
    chk("t6_ready0", req0_ready, 1);
    @(negedge PCLK); req0_valid = 0;
    @(negedge PCLK); #1;
    chk("t6_acc_pen", PENABLE, 1);
    #2 PRESETn = 1;
    #1;
    chk("t6_rst_psel",  PSEL_GPIO, 0);
    chk("t6_rst_pen",   PENABLE,   0);
    chk("t6_rst_paddr", PADDR,     0);
    @(negedge PCLK);
    PRESETn = 0; PREADY_GPIO = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); #1;
      chk("t6_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
    end
    req0_valid = 1; req0_addr = 32'h4;
    req1_valid = 1; req1_addr = 32'h8;
    #1;
    chk("t6_post_ready0", req0_ready, 1);
    chk("t6_post_ready1", req1_ready, 0);
    @(negedge PCLK);
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(negedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
